// File: rtl/psx_pad_responder.sv
// PSX digital-pad emulator: answers a host poll (att/psx_clk/cmd) with FF,41,5A,buttons
// on dat, and drives the ack handshake after each acknowledged byte.
module psx_pad_responder #(
  parameter int ACK_DELAY = 8,
  parameter int ACK_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        att,
  input  logic        psx_clk,
  input  logic        cmd,
  input  logic [15:0] buttons,
  output logic        dat,
  output logic        ack,
  output logic [7:0]  rx_cmd,
  output logic        rx_valid,
  output logic        poll_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ID, S_MARK, S_BTN_LO, S_BTN_HI, S_IGNORE
  } state_t;

  typedef enum logic [1:0] {ACK_IDLE, ACK_WAIT, ACK_LOW} ack_phase_t;

  localparam int CW = 16;

  logic [1:0]  att_sync_q, clk_sync_q, cmd_sync_q;
  logic        att_prev_q, clk_prev_q;
  state_t      state_q, state_d;
  ack_phase_t  ack_phase_q;
  logic [CW-1:0] ack_cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic [15:0] buttons_q;
  logic        dat_q, ack_q, rx_valid_q, poll_done_q;
  logic [7:0]  rx_cmd_q;

  logic att_s, clk_s, cmd_s;
  logic att_fall, att_rise, clk_fall, clk_rise;
  logic shifting, byte_done, ack_req;
  logic [7:0] tx_byte, rx_byte;

  // Synchronisers idle high so reset never produces a spurious edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      att_sync_q <= 2'b11;
      clk_sync_q <= 2'b11;
      cmd_sync_q <= 2'b11;
      att_prev_q <= 1'b1;
      clk_prev_q <= 1'b1;
    end else begin
      att_sync_q <= {att_sync_q[0], att};
      clk_sync_q <= {clk_sync_q[0], psx_clk};
      cmd_sync_q <= {cmd_sync_q[0], cmd};
      att_prev_q <= att_sync_q[1];
      clk_prev_q <= clk_sync_q[1];
    end
  end

  assign att_s    = att_sync_q[1];
  assign clk_s    = clk_sync_q[1];
  assign cmd_s    = cmd_sync_q[1];
  assign att_fall = att_prev_q & ~att_s;
  assign att_rise = ~att_prev_q & att_s;
  assign clk_fall = clk_prev_q & ~clk_s;
  assign clk_rise = ~clk_prev_q & clk_s;

  assign shifting  = (state_q != S_IDLE) && (state_q != S_IGNORE);
  assign byte_done = shifting && clk_rise && (bit_idx_q == 3'd7);

  always_comb begin
    rx_byte            = shift_q;
    rx_byte[bit_idx_q] = cmd_s;
    tx_byte = 8'hFF;
    state_d = S_IGNORE;
    ack_req = 1'b0;
    case (state_q)
      S_ADDR: begin
        if (rx_byte == 8'h01) begin
          state_d = S_ID;
          ack_req = 1'b1;
        end
      end
      S_ID: begin
        tx_byte = 8'h41;
        if (rx_byte == 8'h42) begin
          state_d = S_MARK;
          ack_req = 1'b1;
        end
      end
      S_MARK: begin
        tx_byte = 8'h5A;
        state_d = S_BTN_LO;
        ack_req = 1'b1;
      end
      S_BTN_LO: begin
        tx_byte = buttons_q[7:0];
        state_d = S_BTN_HI;
        ack_req = 1'b1;
      end
      S_BTN_HI: tx_byte = buttons_q[15:8];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ack_phase_q <= ACK_IDLE;
      ack_cnt_q   <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      buttons_q   <= 16'hFFFF;
      dat_q       <= 1'b1;
      ack_q       <= 1'b1;
      rx_cmd_q    <= 8'h00;
      rx_valid_q  <= 1'b0;
      poll_done_q <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      poll_done_q <= 1'b0;
      if (att_rise) begin
        // Abort wins over everything, including a byte completing this cycle.
        state_q     <= S_IDLE;
        ack_phase_q <= ACK_IDLE;
        ack_q       <= 1'b1;
        dat_q       <= 1'b1;
        bit_idx_q   <= 3'd0;
      end else begin
        if (byte_done && ack_req) begin
          ack_phase_q <= ACK_WAIT;
          ack_cnt_q   <= CW'(ACK_DELAY);
          ack_q       <= 1'b1;
        end else begin
          case (ack_phase_q)
            ACK_WAIT: begin
              if (ack_cnt_q == '0) begin
                ack_phase_q <= ACK_LOW;
                ack_q       <= 1'b0;
                ack_cnt_q   <= CW'(ACK_WIDTH - 1);
              end else begin
                ack_cnt_q <= ack_cnt_q - 1'b1;
              end
            end
            ACK_LOW: begin
              if (ack_cnt_q == '0) begin
                ack_phase_q <= ACK_IDLE;
                ack_q       <= 1'b1;
              end else begin
                ack_cnt_q <= ack_cnt_q - 1'b1;
              end
            end
            default: ack_q <= 1'b1;
          endcase
        end

        case (state_q)
          S_IDLE: begin
            dat_q     <= 1'b1;
            bit_idx_q <= 3'd0;
            if (att_fall) begin
              state_q   <= S_ADDR;
              buttons_q <= buttons;
            end
          end
          S_IGNORE: dat_q <= 1'b1;
          default: begin
            if (clk_fall) dat_q <= tx_byte[bit_idx_q];
            if (clk_rise) begin
              if (bit_idx_q == 3'd7) begin
                rx_cmd_q    <= rx_byte;
                rx_valid_q  <= 1'b1;
                bit_idx_q   <= 3'd0;
                dat_q       <= 1'b1;
                state_q     <= state_d;
                poll_done_q <= (state_q == S_BTN_HI);
              end else begin
                shift_q   <= rx_byte;
                bit_idx_q <= bit_idx_q + 3'd1;
              end
            end
          end
        endcase
      end
    end
  end

  assign dat       = dat_q;
  assign ack       = ack_q;
  assign rx_cmd    = rx_cmd_q;
  assign rx_valid  = rx_valid_q;
  assign poll_done = poll_done_q;

endmodule

// File: tb/tb_psx_pad_responder.sv
// Bench for psx_pad_responder: acts as the PSX host and checks replies, acks and
// strobes against a poll-level reference model.
`timescale 1ns/1ps
module tb_psx_pad_responder;

  localparam int ACK_DELAY = 8;
  localparam int ACK_WIDTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        att = 1'b1;
  logic        psx_clk = 1'b1;
  logic        cmd = 1'b1;
  logic [15:0] buttons = 16'hFFFF;
  wire         dat, ack, rx_valid, poll_done;
  wire  [7:0]  rx_cmd;

  psx_pad_responder #(.ACK_DELAY(ACK_DELAY), .ACK_WIDTH(ACK_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .att(att), .psx_clk(psx_clk), .cmd(cmd),
    .buttons(buttons), .dat(dat), .ack(ack), .rx_cmd(rx_cmd),
    .rx_valid(rx_valid), .poll_done(poll_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observation log, sampled on the falling edge
  logic [7:0] rx_val_q[$];
  int         rx_cyc_q[$];
  int         ack_start_q[$];
  int         ack_w_q[$];
  int         pd_cnt = 0;
  int         pd_cyc = -1;
  int         low_cnt = 0;
  logic       ack_last = 1'b1;

  logic [7:0] got[5];
  int         rise_cyc[5];

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_val_q.push_back(rx_cmd);
      rx_cyc_q.push_back(cyc);
    end
    if (poll_done) begin
      pd_cnt = pd_cnt + 1;
      pd_cyc = cyc;
    end
    if (!ack && ack_last) ack_start_q.push_back(cyc);
    if (!ack) low_cnt = low_cnt + 1;
    else if (!ack_last) begin
      ack_w_q.push_back(low_cnt);
      low_cnt = 0;
    end
    ack_last = ack;
  end

  task automatic clear_mon();
    rx_val_q.delete();
    rx_cyc_q.delete();
    ack_start_q.delete();
    ack_w_q.delete();
    pd_cnt = 0;
    pd_cyc = -1;
  endtask

  // One host byte: 5 cycles low, 5 cycles high per bit; dat sampled just before the rise.
  task automatic send_byte(input logic [7:0] c, output logic [7:0] g, output int rc);
    g  = 8'h00;
    rc = 0;
    for (int b = 0; b < 8; b++) begin
      psx_clk = 1'b0;
      cmd     = c[b];
      repeat (5) @(negedge clk);
      g[b]    = dat;
      psx_clk = 1'b1;
      rc      = cyc;
      repeat (5) @(negedge clk);
    end
    cmd = 1'b1;
  endtask

  task automatic run_poll(input logic [39:0] cmds, input logic [15:0] btn,
                          input int chg_at, input logic [15:0] btn2);
    logic [7:0] g;
    int rc;
    clear_mon();
    buttons = btn;
    @(negedge clk);
    att = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (i == chg_at) buttons = btn2;
      send_byte(cmds[8*i +: 8], g, rc);
      got[i]      = g;
      rise_cyc[i] = rc;
      repeat (20) @(negedge clk);
    end
    att = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  // Reference: a pad answers FF,41,5A,lo,hi while the host keeps addressing it correctly,
  // and once it stops listening it returns FF and stays silent until att rises.
  task automatic check_poll(input string tag, input logic [39:0] cmds, input logic [15:0] btn);
    logic [7:0] c0, c1, exp_b;
    logic [7:0] std[5];
    int n_rx;
    int exp_ack[$];
    c0 = cmds[7:0];
    c1 = cmds[15:8];
    n_rx = (c0 != 8'h01) ? 1 : ((c1 != 8'h42) ? 2 : 5);
    std[0] = 8'hFF; std[1] = 8'h41; std[2] = 8'h5A; std[3] = btn[7:0]; std[4] = btn[15:8];
    for (int i = 0; i < 5; i++) begin
      exp_b = (i < n_rx) ? std[i] : 8'hFF;
      n_cmp++;
      if (got[i] !== exp_b) begin
        n_err++;
        $display("FAIL %s dat_byte%0d: got %h want %h", tag, i, got[i], exp_b);
      end
      if (i < n_rx && i < 4 && !(i == 0 && c0 != 8'h01) && !(i == 1 && c1 != 8'h42))
        exp_ack.push_back(i);
    end
    n_cmp++;
    if (rx_val_q.size() !== n_rx) begin
      n_err++;
      $display("FAIL %s rx_count: got %0d want %0d", tag, rx_val_q.size(), n_rx);
    end else begin
      for (int i = 0; i < n_rx; i++) begin
        n_cmp++;
        if (rx_val_q[i] !== cmds[8*i +: 8]) begin
          n_err++;
          $display("FAIL %s rx_cmd%0d: got %h want %h", tag, i, rx_val_q[i], cmds[8*i +: 8]);
        end
        n_cmp++;
        if (rx_cyc_q[i] - rise_cyc[i] !== 3) begin
          n_err++;
          $display("FAIL %s rx_latency%0d: got %0d want 3", tag, i, rx_cyc_q[i] - rise_cyc[i]);
        end
      end
      n_cmp++;
      if (ack_start_q.size() !== exp_ack.size() || ack_w_q.size() !== exp_ack.size()) begin
        n_err++;
        $display("FAIL %s ack_count: got %0d/%0d want %0d", tag, ack_start_q.size(),
                 ack_w_q.size(), exp_ack.size());
      end else begin
        for (int k = 0; k < exp_ack.size(); k++) begin
          n_cmp++;
          if (ack_start_q[k] - rx_cyc_q[exp_ack[k]] !== ACK_DELAY + 1) begin
            n_err++;
            $display("FAIL %s ack_delay%0d: got %0d want %0d", tag, k,
                     ack_start_q[k] - rx_cyc_q[exp_ack[k]], ACK_DELAY + 1);
          end
          n_cmp++;
          if (ack_w_q[k] !== ACK_WIDTH) begin
            n_err++;
            $display("FAIL %s ack_width%0d: got %0d want %0d", tag, k, ack_w_q[k], ACK_WIDTH);
          end
        end
      end
      if (n_rx == 5) begin
        n_cmp++;
        if (pd_cyc !== rx_cyc_q[4]) begin
          n_err++;
          $display("FAIL %s poll_done_cycle: got %0d want %0d", tag, pd_cyc, rx_cyc_q[4]);
        end
      end
    end
    n_cmp++;
    if (pd_cnt !== ((n_rx == 5) ? 1 : 0)) begin
      n_err++;
      $display("FAIL %s poll_done_count: got %0d want %0d", tag, pd_cnt, (n_rx == 5) ? 1 : 0);
    end
    $display("poll %s cmds=%h btn=%h reply=%h %h %h %h %h", tag, cmds, btn,
             got[0], got[1], got[2], got[3], got[4]);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (dat !== 1'b1)       begin n_err++; $display("FAIL reset_dat: got %b want 1", dat); end
    n_cmp++; if (ack !== 1'b1)       begin n_err++; $display("FAIL reset_ack: got %b want 1", ack); end
    n_cmp++; if (rx_cmd !== 8'h00)   begin n_err++; $display("FAIL reset_rx_cmd: got %h want 00", rx_cmd); end
    n_cmp++; if (rx_valid !== 1'b0)  begin n_err++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    n_cmp++; if (poll_done !== 1'b0) begin n_err++; $display("FAIL reset_poll_done: got %b want 0", poll_done); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    $display("reset checked");
  endtask

  task automatic test_full_poll();
    logic [39:0] c;
    c = {8'h00, 8'h00, 8'h00, 8'h42, 8'h01};
    run_poll(c, 16'hFFFE, -1, 16'h0000);
    check_poll("full", c, 16'hFFFE);
  endtask

  task automatic test_random_polls();
    logic [39:0] c;
    logic [15:0] b;
    for (int n = 0; n < 4; n++) begin
      b = 16'($urandom);
      c = {8'($urandom), 8'($urandom), 8'($urandom), 8'h42, 8'h01};
      run_poll(c, b, -1, 16'h0000);
      check_poll("random", c, b);
    end
  endtask

  task automatic test_wrong_addr();
    logic [39:0] c;
    logic [7:0] a;
    logic [15:0] b;
    c = {8'h00, 8'h00, 8'h00, 8'h42, 8'h81};
    run_poll(c, 16'h0F0F, -1, 16'h0000);
    check_poll("wrong_addr", c, 16'h0F0F);
    do a = 8'($urandom); while (a == 8'h01);
    c = {8'($urandom), 8'($urandom), 8'($urandom), 8'h42, a};
    run_poll(c, 16'h5555, -1, 16'h0000);
    check_poll("wrong_addr_rand", c, 16'h5555);
    b = 16'($urandom);
    c = {8'h00, 8'h00, 8'h00, 8'h42, 8'h01};
    run_poll(c, b, -1, 16'h0000);
    check_poll("after_wrong_addr", c, b);
  endtask

  task automatic test_wrong_cmd();
    logic [39:0] c;
    logic [7:0] m;
    c = {8'h00, 8'h00, 8'h00, 8'h43, 8'h01};
    run_poll(c, 16'h1111, -1, 16'h0000);
    check_poll("wrong_cmd", c, 16'h1111);
    do m = 8'($urandom); while (m == 8'h42);
    c = {8'($urandom), 8'($urandom), 8'($urandom), m, 8'h01};
    run_poll(c, 16'h2222, -1, 16'h0000);
    check_poll("wrong_cmd_rand", c, 16'h2222);
  endtask

  task automatic test_button_latch();
    logic [39:0] c;
    c = {8'h00, 8'h00, 8'h00, 8'h42, 8'h01};
    run_poll(c, 16'h1234, 2, 16'hABCD);
    check_poll("button_latch", c, 16'h1234);
  endtask

  task automatic test_abort();
    logic [7:0] g;
    logic [15:0] b;
    logic [39:0] c;
    int rc;
    b = 16'($urandom) & ~16'h0008;
    clear_mon();
    buttons = b;
    @(negedge clk);
    att = 1'b0;
    repeat (6) @(negedge clk);
    send_byte(8'h01, g, rc);
    repeat (20) @(negedge clk);
    send_byte(8'h42, g, rc);
    repeat (20) @(negedge clk);
    send_byte(8'h00, g, rc);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      psx_clk = 1'b0; cmd = 1'b0;
      repeat (5) @(negedge clk);
      psx_clk = 1'b1;
      repeat (5) @(negedge clk);
    end
    psx_clk = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (dat !== b[3]) begin
      n_err++;
      $display("FAIL abort_dat_before: got %b want %b", dat, b[3]);
    end
    att = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (dat !== 1'b1) begin n_err++; $display("FAIL abort_dat: got %b want 1", dat); end
    n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL abort_ack: got %b want 1", ack); end
    psx_clk = 1'b1; cmd = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (rx_val_q.size() !== 3) begin
      n_err++;
      $display("FAIL abort_rx_count: got %0d want 3", rx_val_q.size());
    end
    n_cmp++;
    if (pd_cnt !== 0) begin
      n_err++;
      $display("FAIL abort_poll_done: got %0d want 0", pd_cnt);
    end
    $display("abort btn=%h rx_count=%0d", b, rx_val_q.size());
    b = 16'($urandom);
    c = {8'h00, 8'h00, 8'h00, 8'h42, 8'h01};
    run_poll(c, b, -1, 16'h0000);
    check_poll("after_abort", c, b);
  endtask

  task automatic test_reset_during_ack();
    logic [7:0] g;
    logic [15:0] b;
    logic [39:0] c;
    int rc;
    int waited;
    clear_mon();
    buttons = 16'hBEEF;
    @(negedge clk);
    att = 1'b0;
    repeat (6) @(negedge clk);
    send_byte(8'h01, g, rc);
    waited = 0;
    while (ack !== 1'b0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (ack !== 1'b0) begin
      n_err++;
      $display("FAIL rst_ack_wait: got ack=%b want 0 within 50 cycles", ack);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ack !== 1'b1)     begin n_err++; $display("FAIL rst_ack: got %b want 1", ack); end
    n_cmp++; if (dat !== 1'b1)     begin n_err++; $display("FAIL rst_dat: got %b want 1", dat); end
    n_cmp++; if (rx_cmd !== 8'h00) begin n_err++; $display("FAIL rst_rx_cmd: got %h want 00", rx_cmd); end
    att = 1'b1;
    psx_clk = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    $display("reset during ack waited=%0d", waited);
    b = 16'($urandom);
    c = {8'h00, 8'h00, 8'h00, 8'h42, 8'h01};
    run_poll(c, b, -1, 16'h0000);
    check_poll("after_reset", c, b);
  endtask

  initial begin
    test_reset();
    test_full_poll();
    test_random_polls();
    test_wrong_addr();
    test_wrong_cmd();
    test_button_latch();
    test_abort();
    test_reset_during_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
